// File: rtl/store_sequencer_if.sv
// Request/memory-write bundle between the control FSM, the store sequencer and the memory port.
// Store-op encodings are provided here when the decoder has not already defined them.
`ifndef STORE_OP_WIDTH
`define STORE_OP_WIDTH 2
`endif
`ifndef STORE_OP_SB
`define STORE_OP_SB 2'd0
`endif
`ifndef STORE_OP_SH
`define STORE_OP_SH 2'd1
`endif
`ifndef STORE_OP_SW
`define STORE_OP_SW 2'd2
`endif

interface store_sequencer_if #(
  parameter int XLEN = 32
);
  logic                       req_valid;
  logic                       req_ready;
  logic [`STORE_OP_WIDTH-1:0] req_storeop;
  logic [XLEN-1:0]            req_addr;
  logic [XLEN-1:0]            req_data;
  logic                       mem_valid;
  logic                       mem_ready;
  logic [XLEN-1:0]            mem_addr;
  logic [XLEN-1:0]            mem_wdata;
  logic [3:0]                 mem_wstrb;
  logic                       done;
  logic                       err_misaligned;

  // Environment side: control FSM issues requests, memory accepts beats.
  modport master (
    output req_valid, req_storeop, req_addr, req_data, mem_ready,
    input  req_ready, mem_valid, mem_addr, mem_wdata, mem_wstrb, done, err_misaligned
  );

  modport slave (
    input  req_valid, req_storeop, req_addr, req_data, mem_ready,
    output req_ready, mem_valid, mem_addr, mem_wdata, mem_wstrb, done, err_misaligned
  );
endinterface

// File: rtl/store_sequencer.sv
// Store sequencer: drives one decoded SB/SH/SW store onto the word-wide memory write port.
// Macro KIANV_STORE_SPLIT_EN splits word-crossing stores into two beats; otherwise they are rejected.
module store_sequencer #(
  parameter int XLEN = 32
) (
  input logic              clk,
  input logic              rst,
  store_sequencer_if.slave bus
);

  typedef enum logic [1:0] {IDLE, WR0, WR1, DONE} state_e;

  state_e          state_q, state_d;
  logic            mem_valid_q, mem_valid_d;
  logic [XLEN-1:0] mem_addr_q, mem_addr_d;
  logic [XLEN-1:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]      mem_wstrb_q, mem_wstrb_d;
  logic            err_q, err_d;
`ifdef KIANV_STORE_SPLIT_EN
  logic            cross_q, cross_d;
  logic [XLEN-1:0] addr1_q, addr1_d;
  logic [XLEN-1:0] wdata1_q, wdata1_d;
  logic [3:0]      wstrb1_q, wstrb1_d;
`endif

  logic [1:0]      off;
  logic [2:0]      size;
  logic [3:0]      mask;
  logic            crosses;
  logic [XLEN-1:0] addr0;
  logic [XLEN-1:0] wdata0;
  logic [3:0]      wstrb0;

  function automatic logic [2:0] op_size(input logic [`STORE_OP_WIDTH-1:0] op);
    case (op)
      `STORE_OP_SB: op_size = 3'd1;
      `STORE_OP_SH: op_size = 3'd2;
      default:      op_size = 3'd4;
    endcase
  endfunction

  function automatic logic [3:0] size_mask(input logic [2:0] sz);
    case (sz)
      3'd1:    size_mask = 4'b0001;
      3'd2:    size_mask = 4'b0011;
      default: size_mask = 4'b1111;
    endcase
  endfunction

  // Beat-0 image is computed straight from the request so it can be registered at acceptance.
  always_comb begin
    off     = bus.req_addr[1:0];
    size    = op_size(bus.req_storeop);
    mask    = size_mask(size);
    crosses = (({1'b0, off} + size) > 3'd4);
    addr0   = {bus.req_addr[XLEN-1:2], 2'b00};
    wdata0  = bus.req_data << {off, 3'b000};
    wstrb0  = mask << off;
  end

  always_comb begin
    state_d     = state_q;
    mem_valid_d = mem_valid_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wstrb_d = mem_wstrb_q;
    err_d       = 1'b0;
`ifdef KIANV_STORE_SPLIT_EN
    cross_d     = cross_q;
    addr1_d     = addr1_q;
    wdata1_d    = wdata1_q;
    wstrb1_d    = wstrb1_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
`ifdef KIANV_STORE_SPLIT_EN
          state_d     = WR0;
          mem_valid_d = 1'b1;
          mem_addr_d  = addr0;
          mem_wdata_d = wdata0;
          mem_wstrb_d = wstrb0;
          cross_d     = crosses;
          addr1_d     = addr0 + XLEN'(4);
          wdata1_d    = bus.req_data >> {(3'd4 - {1'b0, off}), 3'b000};
          wstrb1_d    = mask >> (3'd4 - {1'b0, off});
`else
          if (crosses) begin
            state_d = DONE;
            err_d   = 1'b1;
          end else begin
            state_d     = WR0;
            mem_valid_d = 1'b1;
            mem_addr_d  = addr0;
            mem_wdata_d = wdata0;
            mem_wstrb_d = wstrb0;
          end
`endif
        end
      end
      WR0: begin
        if (bus.mem_ready) begin
`ifdef KIANV_STORE_SPLIT_EN
          if (cross_q) begin
            state_d     = WR1;
            mem_addr_d  = addr1_q;
            mem_wdata_d = wdata1_q;
            mem_wstrb_d = wstrb1_q;
          end else begin
            state_d     = DONE;
            mem_valid_d = 1'b0;
          end
`else
          state_d     = DONE;
          mem_valid_d = 1'b0;
`endif
        end
      end
`ifdef KIANV_STORE_SPLIT_EN
      WR1: begin
        if (bus.mem_ready) begin
          state_d     = DONE;
          mem_valid_d = 1'b0;
        end
      end
`endif
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      mem_valid_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_valid_q <= mem_valid_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wstrb_q <= mem_wstrb_d;
      err_q       <= err_d;
    end
  end

`ifdef KIANV_STORE_SPLIT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      cross_q <= 1'b0;
    end else begin
      cross_q <= cross_d;
    end
    addr1_q  <= addr1_d;
    wdata1_q <= wdata1_d;
    wstrb1_q <= wstrb1_d;
  end
`endif

  assign bus.req_ready      = (state_q == IDLE);
  assign bus.mem_valid      = mem_valid_q;
  assign bus.mem_addr       = mem_addr_q;
  assign bus.mem_wdata      = mem_wdata_q;
  assign bus.mem_wstrb      = mem_wstrb_q;
  assign bus.done           = (state_q == DONE);
  assign bus.err_misaligned = err_q;

endmodule

// File: tb/tb_store_sequencer.sv
// Directed bench for store_sequencer: byte-lane placement, word crossing, stalls and reset abort.
`ifndef STORE_OP_WIDTH
`define STORE_OP_WIDTH 2
`endif
`ifndef STORE_OP_SB
`define STORE_OP_SB 2'd0
`endif
`ifndef STORE_OP_SH
`define STORE_OP_SH 2'd1
`endif
`ifndef STORE_OP_SW
`define STORE_OP_SW 2'd2
`endif

module tb_store_sequencer;
  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  store_sequencer_if #(.XLEN(32)) bus ();

  store_sequencer #(.XLEN(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_beat(input string tag, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s);
    check_eq({tag, ".valid"}, 32'(bus.mem_valid), 32'd1);
    check_eq({tag, ".addr"},  bus.mem_addr,        a);
    check_eq({tag, ".wdata"}, bus.mem_wdata,       d);
    check_eq({tag, ".wstrb"}, 32'(bus.mem_wstrb),  32'(s));
    check_eq({tag, ".done"},  32'(bus.done),       32'd0);
    check_eq({tag, ".rdy"},   32'(bus.req_ready),  32'd0);
  endtask

  // One complete store; junk requests are offered during stalls and must be ignored.
  task automatic run_store(input string tag, input logic [1:0] op, input logic [31:0] addr,
                           input logic [31:0] data, input int stall, input bit exp_err,
                           input int beats,
                           input logic [31:0] a0, input logic [31:0] d0, input logic [3:0] s0,
                           input logic [31:0] a1, input logic [31:0] d1, input logic [3:0] s1);
    check_eq({tag, ".idle_rdy"}, 32'(bus.req_ready), 32'd1);
    bus.req_valid   = 1'b1;
    bus.req_storeop = op;
    bus.req_addr    = addr;
    bus.req_data    = data;
    bus.mem_ready   = 1'b0;
    tick();
    bus.req_valid = 1'b0;
    if (exp_err) begin
      check_eq({tag, ".err_valid"}, 32'(bus.mem_valid),      32'd0);
      check_eq({tag, ".err_done"},  32'(bus.done),           32'd1);
      check_eq({tag, ".err_flag"},  32'(bus.err_misaligned), 32'd1);
    end else begin
      for (int b = 0; b < beats; b++) begin
        string bt;
        bt = $sformatf("%s.b%0d", tag, b);
        check_beat(bt, (b == 0) ? a0 : a1, (b == 0) ? d0 : d1, (b == 0) ? s0 : s1);
        for (int s = 0; s < stall; s++) begin
          bus.req_valid = 1'b1;
          bus.req_addr  = 32'h0BAD_0000;
          bus.req_data  = 32'hFFFF_FFFF;
          tick();
          check_beat({bt, ".stall"}, (b == 0) ? a0 : a1, (b == 0) ? d0 : d1,
                     (b == 0) ? s0 : s1);
        end
        bus.req_valid = 1'b0;
        bus.mem_ready = 1'b1;
        tick();
        bus.mem_ready = 1'b0;
      end
      check_eq({tag, ".fin_valid"}, 32'(bus.mem_valid),      32'd0);
      check_eq({tag, ".fin_done"},  32'(bus.done),           32'd1);
      check_eq({tag, ".fin_err"},   32'(bus.err_misaligned), 32'd0);
    end
    tick();
    check_eq({tag, ".post_done"},  32'(bus.done),           32'd0);
    check_eq({tag, ".post_err"},   32'(bus.err_misaligned), 32'd0);
    check_eq({tag, ".post_rdy"},   32'(bus.req_ready),      32'd1);
    check_eq({tag, ".post_valid"}, 32'(bus.mem_valid),      32'd0);
  endtask

  initial begin
    n_tests         = 0;
    n_fail          = 0;
    rst             = 1'b1;
    bus.req_valid   = 1'b0;
    bus.req_storeop = `STORE_OP_SW;
    bus.req_addr    = 32'h0;
    bus.req_data    = 32'h0;
    bus.mem_ready   = 1'b0;
    tick();
    tick();
    check_eq("rst.valid", 32'(bus.mem_valid),      32'd0);
    check_eq("rst.addr",  bus.mem_addr,            32'h0);
    check_eq("rst.wdata", bus.mem_wdata,           32'h0);
    check_eq("rst.wstrb", 32'(bus.mem_wstrb),      32'd0);
    check_eq("rst.done",  32'(bus.done),           32'd0);
    check_eq("rst.err",   32'(bus.err_misaligned), 32'd0);
    check_eq("rst.rdy",   32'(bus.req_ready),      32'd1);
    rst = 1'b0;
    tick();

    run_store("sw_al",  `STORE_OP_SW, 32'h0000_0100, 32'hDEAD_BEEF, 0, 1'b0, 1,
              32'h0000_0100, 32'hDEAD_BEEF, 4'b1111, 32'h0, 32'h0, 4'b0000);
    run_store("sb_o3",  `STORE_OP_SB, 32'h0000_0203, 32'h0000_00A5, 0, 1'b0, 1,
              32'h0000_0200, 32'hA500_0000, 4'b1000, 32'h0, 32'h0, 4'b0000);
    run_store("sh_o1",  `STORE_OP_SH, 32'h0000_0301, 32'h0000_1234, 1, 1'b0, 1,
              32'h0000_0300, 32'h0012_3400, 4'b0110, 32'h0, 32'h0, 4'b0000);
    run_store("sb_o1",  `STORE_OP_SB, 32'h0000_0101, 32'hFFFF_FF5A, 0, 1'b0, 1,
              32'h0000_0100, 32'hFFFF_5A00, 4'b0010, 32'h0, 32'h0, 4'b0000);
    run_store("op3_sw", 2'd3,         32'h0000_0000, 32'h0102_0304, 0, 1'b0, 1,
              32'h0000_0000, 32'h0102_0304, 4'b1111, 32'h0, 32'h0, 4'b0000);
    run_store("sh_top", `STORE_OP_SH, 32'hFFFF_FFFE, 32'h0000_BEEF, 3, 1'b0, 1,
              32'hFFFF_FFFC, 32'hBEEF_0000, 4'b1100, 32'h0, 32'h0, 4'b0000);
`ifdef KIANV_STORE_SPLIT_EN
    run_store("sw_x2",  `STORE_OP_SW, 32'h0000_0402, 32'hAABB_CCDD, 0, 1'b0, 2,
              32'h0000_0400, 32'hCCDD_0000, 4'b1100, 32'h0000_0404, 32'h0000_AABB, 4'b0011);
    run_store("sh_x3",  `STORE_OP_SH, 32'h0000_0303, 32'h0000_1234, 1, 1'b0, 2,
              32'h0000_0300, 32'h3400_0000, 4'b1000, 32'h0000_0304, 32'h0000_0012, 4'b0001);
    run_store("sw_wrap", `STORE_OP_SW, 32'hFFFF_FFFF, 32'h1122_3344, 3, 1'b0, 2,
              32'hFFFF_FFFC, 32'h4400_0000, 4'b1000, 32'h0000_0000, 32'h0011_2233, 4'b0111);
`else
    run_store("sw_x2",  `STORE_OP_SW, 32'h0000_0402, 32'hAABB_CCDD, 0, 1'b1, 0,
              32'h0, 32'h0, 4'b0000, 32'h0, 32'h0, 4'b0000);
    run_store("sh_x3",  `STORE_OP_SH, 32'h0000_0303, 32'h0000_1234, 0, 1'b1, 0,
              32'h0, 32'h0, 4'b0000, 32'h0, 32'h0, 4'b0000);
    run_store("sw_wrap", `STORE_OP_SW, 32'hFFFF_FFFF, 32'h1122_3344, 3, 1'b1, 0,
              32'h0, 32'h0, 4'b0000, 32'h0, 32'h0, 4'b0000);
`endif

    // Reset during a WR0 stall aborts without a done pulse.
    bus.req_valid   = 1'b1;
    bus.req_storeop = `STORE_OP_SW;
    bus.req_addr    = 32'h0000_0500;
    bus.req_data    = 32'h5566_7788;
    bus.mem_ready   = 1'b0;
    tick();
    bus.req_valid = 1'b0;
    check_eq("abort.valid0", 32'(bus.mem_valid), 32'd1);
    tick();
    rst = 1'b1;
    tick();
    check_eq("abort.valid", 32'(bus.mem_valid), 32'd0);
    check_eq("abort.rdy",   32'(bus.req_ready), 32'd1);
    check_eq("abort.done",  32'(bus.done),      32'd0);
    check_eq("abort.addr",  bus.mem_addr,       32'h0);
    check_eq("abort.wstrb", 32'(bus.mem_wstrb), 32'd0);
    rst = 1'b0;
    tick();
    check_eq("abort.done2", 32'(bus.done),      32'd0);
    check_eq("abort.valid2", 32'(bus.mem_valid), 32'd0);
    run_store("sb_after", `STORE_OP_SB, 32'h0000_0502, 32'h0000_00C3, 0, 1'b0, 1,
              32'h0000_0500, 32'h00C3_0000, 4'b0100, 32'h0, 32'h0, 4'b0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
